register_file_ckpt: RTL and testbench
=====================================

REGISTER_FILE_CKPT -- requirements
Module: register_file_ckpt

Interface
REQ-001 SHALL have parameter REG_N, default 32: architectural register count; index width RB = clog2(REG_N).
REQ-002 SHALL have parameter DAT_W, default 32: data width.
REQ-003 SHALL have parameter TAG_W, default 4: ROB tag width; tag 0 means "no dependency".
REQ-004 SHALL have parameter CKPT_N, default 4 (power of two): checkpoint slots; index width CB.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1: global advance; when low, all state holds.
REQ-008 SHALL have port is_en_i/is_ic_i/is_tp_i[1:0]/is_op_i/is_imm_i/is_pc_i, input: issue payload from decoder.
REQ-009 SHALL have port is_rd_i/is_rs1_i/is_rs2_i, input, RB each: destination and source registers.
REQ-010 SHALL have port is_tag_i, input, TAG_W: ROB tag allocated to the issuing instruction.
REQ-011 SHALL have port is_br_i, input, 1: issuing instruction is a branch and requires a checkpoint.
REQ-012 SHALL have port ckpt_id_o, output, CB: slot the next branch will take (combinational, tail pointer).
REQ-013 SHALL have port ckpt_full_o, output, 1: all slots in use; the decoder shall not issue a branch.
REQ-014 SHALL have port rob_en_i/rob_rd_i/rob_tag_i/rob_v_i/rob_br_i, input: commit of value to rd; rob_br_i releases the oldest checkpoint.
REQ-015 SHALL have port cdb_en_i/cdb_tag_i/cdb_v_i and ldb_en_i/ldb_tag_i/ldb_v_i, input: broadcast results.
REQ-016 SHALL have port br_flag_i, input, 1, plus br_id_i, input, CB: early mispredict of the branch that owns slot br_id_i.
REQ-017 SHALL have port rs_en_o/lsb_en_o, output, 1 each: registered dispatch strobes.
REQ-018 SHALL have port ic_o/op_o/imm_o/pc_o/qj_o/qk_o/vj_o/vk_o/qd_o, output: registered payload, shared by RS and LSB.

Function
REQ-019 SHALL dispatch with 1-cycle latency: on is_en_i, the next cycle asserts lsb_en_o if is_tp_i is 01 or 10, else rs_en_o; each strobe is high for exactly one cycle.
REQ-020 SHALL take qj/vj from the tag table and the register array at rs1 (likewise qk/vk at rs2), and set qd_o = is_tag_i.
REQ-021 SHALL forward, when the source tag is nonzero and matches a same-cycle rob/ldb/cdb result, that value with q=0; priority cdb > ldb > rob.
REQ-022 SHALL, on issue, write tag[is_rd_i] <= is_tag_i; if the same cycle also commits to the same rd, the issue write wins.
REQ-023 SHALL, on commit, write regs[rob_rd_i] <= rob_v_i and clear tag[rob_rd_i] only if it equals rob_tag_i.
REQ-024 SHALL, on commit, also clear every entry equal to rob_tag_i in all valid checkpoints (scrubbing).
REQ-025 SHALL keep register 0 reading value 0 and tag 0 at all times.
REQ-026 SHALL, on issue with is_br_i, copy the post-issue tag table (including this cycle's rd write and commit scrub) into slot ckpt_id_o; tail++ mod CKPT_N; count++.
REQ-027 SHALL, on rob_br_i, advance head and decrement count; with simultaneous allocate and release, count holds.
REQ-028 SHALL, on br_flag_i, restore the tag table from slot br_id_i (with same-cycle commit scrub applied), set tail = br_id_i+1, recompute count, drop any issue that cycle, and clear both dispatch strobes.
REQ-029 SHALL never modify the register values on br_flag_i.
REQ-030 SHALL give br_flag_i priority over is_en_i; rob_en_i is still honoured in the same cycle.
REQ-031 SHALL assert ckpt_full_o exactly when count == CKPT_N; a branch issue while full is ignored for allocation.

Reset
REQ-032 SHALL on rst low, immediately clear all regs, tags, checkpoints, head, tail, count, strobes and payload outputs to 0.
REQ-033 SHALL make reset override any operation in progress; the first issue after release sees all operands ready with value 0.

Configuration
REQ-034 SHALL implement checkpoint storage, allocation, release and restore when RF_CKPT_EN is defined.
REQ-035 SHALL, when RF_CKPT_EN is undefined, omit the checkpoint logic: br_flag_i clears all tags, ckpt_full_o=0, ckpt_id_o=0, and is_br_i/br_id_i/rob_br_i are ignored.

Verification
REQ-036 SHALL cover: reset, then issue add x5 with rs1=x0 -> next cycle rs_en_o=1, qj_o=0, vj_o=0, qd_o=is_tag_i.
REQ-037 SHALL cover: issue rd=x3 tag 2, then rs1=x3 while cdb_tag=2, v=0xAB -> qj_o=0, vj_o=0xAB.
REQ-038 SHALL cover: x3 tag 2, branch checkpoint, x3 reissued with tag 5, br_flag_i on that slot -> tag[x3]=2.
REQ-039 SHALL cover: as REQ-038, but tag 2 commits before br_flag_i -> the restored tag[x3] is 0 and regs[x3] holds the committed value.
REQ-040 SHALL cover (CKPT_N=4): four branches issued -> ckpt_full_o=1; rob_br_i plus branch issue in the same cycle -> ckpt_full_o stays 1.
REQ-041 SHALL cover: rst asserted mid-dispatch -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/register_file_ckpt.sv
// rtl/register_file_ckpt.sv - rename register file with ROB tag table and branch checkpoints
// Checkpoint storage, allocation, release and restore are built only when RF_CKPT_EN is defined.
module register_file_ckpt #(
    parameter int REG_N  = 32,
    parameter int DAT_W  = 32,
    parameter int TAG_W  = 4,
    parameter int CKPT_N = 4,
    localparam int RB = $clog2(REG_N),
    localparam int CB = $clog2(CKPT_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             is_en_i,
    input  logic             is_ic_i,
    input  logic [1:0]       is_tp_i,
    input  logic [3:0]       is_op_i,
    input  logic [DAT_W-1:0] is_imm_i,
    input  logic [DAT_W-1:0] is_pc_i,
    input  logic [RB-1:0]    is_rd_i,
    input  logic [RB-1:0]    is_rs1_i,
    input  logic [RB-1:0]    is_rs2_i,
    input  logic [TAG_W-1:0] is_tag_i,
    input  logic             is_br_i,
    output logic [CB-1:0]    ckpt_id_o,
    output logic             ckpt_full_o,
    input  logic             rob_en_i,
    input  logic [RB-1:0]    rob_rd_i,
    input  logic [TAG_W-1:0] rob_tag_i,
    input  logic [DAT_W-1:0] rob_v_i,
    input  logic             rob_br_i,
    input  logic             cdb_en_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [DAT_W-1:0] cdb_v_i,
    input  logic             ldb_en_i,
    input  logic [TAG_W-1:0] ldb_tag_i,
    input  logic [DAT_W-1:0] ldb_v_i,
    input  logic             br_flag_i,
    input  logic [CB-1:0]    br_id_i,
    output logic             rs_en_o,
    output logic             lsb_en_o,
    output logic             ic_o,
    output logic [3:0]       op_o,
    output logic [DAT_W-1:0] imm_o,
    output logic [DAT_W-1:0] pc_o,
    output logic [TAG_W-1:0] qj_o,
    output logic [TAG_W-1:0] qk_o,
    output logic [DAT_W-1:0] vj_o,
    output logic [DAT_W-1:0] vk_o,
    output logic [TAG_W-1:0] qd_o
);

    logic [DAT_W-1:0] regs_q [REG_N];
    logic [DAT_W-1:0] regs_d [REG_N];
    logic [TAG_W-1:0] tag_q  [REG_N];
    logic [TAG_W-1:0] tag_d  [REG_N];
    logic             rs_en_q, rs_en_d, lsb_en_q, lsb_en_d, ic_q, ic_d;
    logic [3:0]       op_q, op_d;
    logic [DAT_W-1:0] imm_q, imm_d, pc_q, pc_d, vj_q, vj_d, vk_q, vk_d;
    logic [TAG_W-1:0] qj_q, qj_d, qk_q, qk_d, qd_q, qd_d;
    logic [TAG_W+DAT_W-1:0] src1, src2;
    logic             issue;

    // A mispredict squashes whatever the decoder presents in the same cycle.
    assign issue = is_en_i && !br_flag_i;

    function automatic logic [TAG_W+DAT_W-1:0] fwd(input logic [TAG_W-1:0] q,
                                                   input logic [DAT_W-1:0] v);
        logic [TAG_W+DAT_W-1:0] r;
        r = {q, v};
        if (q != '0) begin
            if (cdb_en_i && cdb_tag_i == q)      r = {{TAG_W{1'b0}}, cdb_v_i};
            else if (ldb_en_i && ldb_tag_i == q) r = {{TAG_W{1'b0}}, ldb_v_i};
            else if (rob_en_i && rob_tag_i == q) r = {{TAG_W{1'b0}}, rob_v_i};
        end
        return r;
    endfunction

`ifdef RF_CKPT_EN
    localparam logic [CB:0] CNT_FULL = (CB+1)'(CKPT_N);
    logic [TAG_W-1:0] ckpt_q [CKPT_N][REG_N];
    logic [TAG_W-1:0] ckpt_d [CKPT_N][REG_N];
    logic [CB-1:0]    head_q, head_d, tail_q, tail_d, off;
    logic [CB:0]      cnt_q, cnt_d;
    logic             full, rel, alloc, scrub;

    assign full        = (cnt_q == CNT_FULL);
    assign rel         = rob_br_i && (cnt_q != '0);
    assign alloc       = issue && is_br_i && (!full || rel);
    assign scrub       = rob_en_i && (rob_tag_i != '0);
    assign ckpt_id_o   = tail_q;
    assign ckpt_full_o = full;
`else
    logic unused_ckpt;
    assign unused_ckpt = ^{is_br_i, br_id_i, rob_br_i};
    assign ckpt_id_o   = '0;
    assign ckpt_full_o = 1'b0;
`endif

    always_comb begin
        regs_d = regs_q;
        tag_d  = tag_q;
        if (rob_en_i && rob_rd_i != '0) begin
            regs_d[rob_rd_i] = rob_v_i;
            if (tag_q[rob_rd_i] == rob_tag_i) tag_d[rob_rd_i] = '0;
        end
        if (issue && is_rd_i != '0) tag_d[is_rd_i] = is_tag_i;
`ifdef RF_CKPT_EN
        ckpt_d = ckpt_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        off    = '0;
        for (int s = 0; s < CKPT_N; s++) begin
            off = CB'(s) - head_q;
            if (scrub && ({1'b0, off} < cnt_q)) begin
                for (int r = 0; r < REG_N; r++)
                    if (ckpt_q[s][r] == rob_tag_i) ckpt_d[s][r] = '0;
            end
        end
        if (rel) begin
            head_d = head_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end
        if (br_flag_i) begin
            // The mispredicting branch keeps its own slot; everything younger is freed.
            tag_d  = ckpt_d[br_id_i];
            off    = br_id_i - head_d;
            tail_d = br_id_i + 1'b1;
            cnt_d  = {1'b0, off} + 1'b1;
        end else if (alloc) begin
            ckpt_d[tail_q] = tag_d;
            tail_d         = tail_q + 1'b1;
            cnt_d          = cnt_d + 1'b1;
        end
`else
        if (br_flag_i) begin
            for (int r = 0; r < REG_N; r++) tag_d[r] = '0;
        end
`endif
    end

    always_comb begin
        src1     = fwd(tag_q[is_rs1_i], regs_q[is_rs1_i]);
        src2     = fwd(tag_q[is_rs2_i], regs_q[is_rs2_i]);
        rs_en_d  = 1'b0;
        lsb_en_d = 1'b0;
        ic_d     = ic_q;
        op_d     = op_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        qj_d     = qj_q;
        vj_d     = vj_q;
        qk_d     = qk_q;
        vk_d     = vk_q;
        qd_d     = qd_q;
        if (issue) begin
            lsb_en_d     = (is_tp_i == 2'b01) || (is_tp_i == 2'b10);
            rs_en_d      = !lsb_en_d;
            ic_d         = is_ic_i;
            op_d         = is_op_i;
            imm_d        = is_imm_i;
            pc_d         = is_pc_i;
            {qj_d, vj_d} = src1;
            {qk_d, vk_d} = src2;
            qd_d         = is_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_N; r++) begin
                regs_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            rs_en_q  <= 1'b0;
            lsb_en_q <= 1'b0;
            ic_q     <= 1'b0;
            op_q     <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            qj_q     <= '0;
            vj_q     <= '0;
            qk_q     <= '0;
            vk_q     <= '0;
            qd_q     <= '0;
`ifdef RF_CKPT_EN
            for (int s = 0; s < CKPT_N; s++)
                for (int r = 0; r < REG_N; r++) ckpt_q[s][r] <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
`endif
        end else if (en) begin
            regs_q   <= regs_d;
            tag_q    <= tag_d;
            rs_en_q  <= rs_en_d;
            lsb_en_q <= lsb_en_d;
            ic_q     <= ic_d;
            op_q     <= op_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            qj_q     <= qj_d;
            vj_q     <= vj_d;
            qk_q     <= qk_d;
            vk_q     <= vk_d;
            qd_q     <= qd_d;
`ifdef RF_CKPT_EN
            ckpt_q <= ckpt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign rs_en_o  = rs_en_q;
    assign lsb_en_o = lsb_en_q;
    assign ic_o     = ic_q;
    assign op_o     = op_q;
    assign imm_o    = imm_q;
    assign pc_o     = pc_q;
    assign qj_o     = qj_q;
    assign vj_o     = vj_q;
    assign qk_o     = qk_q;
    assign vk_o     = vk_q;
    assign qd_o     = qd_q;

endmodule

// File: tb/tb_register_file_ckpt.sv
// tb/tb_register_file_ckpt.sv - scoreboard bench for register_file_ckpt (both RF_CKPT_EN builds)
module tb_register_file_ckpt;
`ifdef RF_CKPT_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en;
    logic        is_en_i, is_ic_i, is_br_i;
    logic [1:0]  is_tp_i;
    logic [3:0]  is_op_i, is_tag_i;
    logic [31:0] is_imm_i, is_pc_i;
    logic [4:0]  is_rd_i, is_rs1_i, is_rs2_i;
    logic [1:0]  ckpt_id_o, br_id_i;
    logic        ckpt_full_o;
    logic        rob_en_i, rob_br_i, cdb_en_i, ldb_en_i, br_flag_i;
    logic [4:0]  rob_rd_i;
    logic [3:0]  rob_tag_i, cdb_tag_i, ldb_tag_i;
    logic [31:0] rob_v_i, cdb_v_i, ldb_v_i;
    logic        rs_en_o, lsb_en_o, ic_o;
    logic [3:0]  op_o, qj_o, qk_o, qd_o;
    logic [31:0] imm_o, pc_o, vj_o, vk_o;

    typedef struct {
        logic        lsb;
        logic [3:0]  qj, qk, qd;
        logic [31:0] vj, vk, imm;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    register_file_ckpt dut (
        .clk(clk), .rst(rst), .en(en),
        .is_en_i(is_en_i), .is_ic_i(is_ic_i), .is_tp_i(is_tp_i), .is_op_i(is_op_i),
        .is_imm_i(is_imm_i), .is_pc_i(is_pc_i), .is_rd_i(is_rd_i), .is_rs1_i(is_rs1_i),
        .is_rs2_i(is_rs2_i), .is_tag_i(is_tag_i), .is_br_i(is_br_i),
        .ckpt_id_o(ckpt_id_o), .ckpt_full_o(ckpt_full_o),
        .rob_en_i(rob_en_i), .rob_rd_i(rob_rd_i), .rob_tag_i(rob_tag_i), .rob_v_i(rob_v_i),
        .rob_br_i(rob_br_i),
        .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i), .cdb_v_i(cdb_v_i),
        .ldb_en_i(ldb_en_i), .ldb_tag_i(ldb_tag_i), .ldb_v_i(ldb_v_i),
        .br_flag_i(br_flag_i), .br_id_i(br_id_i),
        .rs_en_o(rs_en_o), .lsb_en_o(lsb_en_o), .ic_o(ic_o), .op_o(op_o), .imm_o(imm_o),
        .pc_o(pc_o), .qj_o(qj_o), .qk_o(qk_o), .vj_o(vj_o), .vk_o(vk_o), .qd_o(qd_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        is_en_i = 0; is_ic_i = 0; is_br_i = 0; is_tp_i = 0; is_op_i = 0; is_tag_i = 0;
        is_imm_i = 0; is_pc_i = 0; is_rd_i = 0; is_rs1_i = 0; is_rs2_i = 0;
        rob_en_i = 0; rob_br_i = 0; rob_rd_i = 0; rob_tag_i = 0; rob_v_i = 0;
        cdb_en_i = 0; cdb_tag_i = 0; cdb_v_i = 0; ldb_en_i = 0; ldb_tag_i = 0; ldb_v_i = 0;
        br_flag_i = 0; br_id_i = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic issue(input int rd, input int rs1, input int rs2, input int tag,
                         input int tp, input bit br, input int eqj, input int evj,
                         input int eqk, input int evk);
        exp_t e;
        is_en_i  = 1'b1;
        is_rd_i  = 5'(rd);
        is_rs1_i = 5'(rs1);
        is_rs2_i = 5'(rs2);
        is_tag_i = 4'(tag);
        is_tp_i  = 2'(tp);
        is_br_i  = br;
        is_imm_i = 32'(tag * 3 + 1);
        is_pc_i  = 32'(tag * 4);
        e.lsb = (tp == 1) || (tp == 2);
        e.qj  = 4'(eqj);
        e.vj  = 32'(evj);
        e.qk  = 4'(eqk);
        e.vk  = 32'(evk);
        e.qd  = 4'(tag);
        e.imm = 32'(tag * 3 + 1);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && (rs_en_o || lsb_en_o)) begin
            if (sb.size() == 0) begin
                check("unexpected_dispatch", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rs_en", 32'(rs_en_o), 32'(!mon_e.lsb));
                check("lsb_en", 32'(lsb_en_o), 32'(mon_e.lsb));
                check("qj", 32'(qj_o), 32'(mon_e.qj));
                check("vj", vj_o, mon_e.vj);
                check("qk", 32'(qk_o), 32'(mon_e.qk));
                check("vk", vk_o, mon_e.vk);
                check("qd", 32'(qd_o), 32'(mon_e.qd));
                check("imm", imm_o, mon_e.imm);
            end
        end
    end

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_rs_en", 32'(rs_en_o), 0);
        check("rst_lsb_en", 32'(lsb_en_o), 0);
        check("rst_qd", 32'(qd_o), 0);
        check("rst_full", 32'(ckpt_full_o), 0);
        check("rst_ckpt_id", 32'(ckpt_id_o), 0);
        rst = 1'b1;

        // Dispatch, forwarding and commit ordering
        issue(5, 0, 0, 1, 0, 0, 0, 0, 0, 0); tick();
        issue(3, 5, 0, 2, 1, 0, 1, 0, 0, 0); tick();
        cdb_en_i = 1; cdb_tag_i = 2; cdb_v_i = 32'hAB;
        ldb_en_i = 1; ldb_tag_i = 1; ldb_v_i = 32'h11;
        issue(6, 3, 5, 3, 0, 0, 0, 'hAB, 0, 'h11); tick();
        cdb_en_i = 1; cdb_tag_i = 2; cdb_v_i = 32'h22;
        ldb_en_i = 1; ldb_tag_i = 2; ldb_v_i = 32'h33;
        rob_en_i = 1; rob_rd_i = 3; rob_tag_i = 2; rob_v_i = 32'h44;
        issue(7, 3, 6, 4, 0, 0, 0, 'h22, 3, 0); tick();
        ldb_en_i = 1; ldb_tag_i = 4; ldb_v_i = 32'h55;
        rob_en_i = 1; rob_rd_i = 7; rob_tag_i = 4; rob_v_i = 32'h66;
        issue(8, 3, 7, 5, 0, 0, 0, 'h44, 0, 'h55); tick();
        rob_en_i = 1; rob_rd_i = 8; rob_tag_i = 5; rob_v_i = 32'h77;
        issue(8, 8, 0, 7, 0, 0, 0, 'h77, 0, 0); tick();
        issue(0, 8, 0, 8, 2, 0, 7, 'h77, 0, 0); tick();
        issue(1, 0, 0, 9, 3, 0, 0, 0, 0, 0); tick();

        // Checkpoint then mispredict restores the older mapping of x3
        issue(3, 0, 0, 2, 0, 0, 0, 0, 0, 0); tick();
        check("ckpt_id_before_br", 32'(ckpt_id_o), 0);
        issue(0, 0, 0, 10, 0, 1, 0, 0, 0, 0); tick();
        check("ckpt_id_after_br", 32'(ckpt_id_o), CK ? 1 : 0);
        issue(3, 0, 0, 5, 0, 0, 0, 0, 0, 0); tick();
        br_flag_i = 1; br_id_i = 0;
        is_en_i = 1; is_rd_i = 4; is_tag_i = 11; is_rs1_i = 3;
        tick();
        check("flush_rs_en", 32'(rs_en_o), 0);
        check("flush_lsb_en", 32'(lsb_en_o), 0);
        issue(10, 3, 4, 12, 0, 0, CK ? 2 : 0, 'h44, 0, 0); tick();

        // Commit of the checkpointed tag scrubs it before the restore
        issue(0, 0, 0, 13, 0, 1, 0, 0, 0, 0); tick();
        issue(3, 0, 0, 14, 0, 0, 0, 0, 0, 0); tick();
        rob_en_i = 1; rob_rd_i = 3; rob_tag_i = 2; rob_v_i = 32'h99;
        tick();
        br_flag_i = 1; br_id_i = 1;
        tick();
        check("ckpt_id_restore", 32'(ckpt_id_o), CK ? 2 : 0);
        issue(11, 3, 0, 15, 0, 0, 0, 'h99, 0, 0); tick();

        // Fill every slot, then release and allocate together
        rob_br_i = 1; tick();
        rob_br_i = 1; tick();
        check("full_empty", 32'(ckpt_full_o), 0);
        for (int i = 1; i <= 3; i++) begin
            issue(0, 0, 0, i, 0, 1, 0, 0, 0, 0); tick();
        end
        check("full_three", 32'(ckpt_full_o), 0);
        issue(0, 0, 0, 4, 0, 1, 0, 0, 0, 0); tick();
        check("full_four", 32'(ckpt_full_o), 32'(CK));
        check("ckpt_id_wrap", 32'(ckpt_id_o), CK ? 2 : 0);
        rob_br_i = 1;
        issue(0, 0, 0, 6, 0, 1, 0, 0, 0, 0); tick();
        check("full_rel_alloc", 32'(ckpt_full_o), 32'(CK));
        check("ckpt_id_rel_alloc", 32'(ckpt_id_o), CK ? 3 : 0);
        issue(0, 0, 0, 7, 0, 1, 0, 0, 0, 0); tick();
        check("full_ignored", 32'(ckpt_full_o), 32'(CK));
        check("ckpt_id_ignored", 32'(ckpt_id_o), CK ? 3 : 0);

        // Asynchronous reset while a dispatch strobe is high
        is_en_i = 1; is_rd_i = 9; is_tag_i = 6; is_rs1_i = 3;
        @(posedge clk);
        #1;
        check("pre_rst_rs_en", 32'(rs_en_o), 1);
        check("pre_rst_qd", 32'(qd_o), 6);
        rst = 1'b0;
        #1;
        check("async_rs_en", 32'(rs_en_o), 0);
        check("async_qd", 32'(qd_o), 0);
        check("async_vj", vj_o, 0);
        check("async_full", 32'(ckpt_full_o), 0);
        check("async_ckpt_id", 32'(ckpt_id_o), 0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        issue(10, 3, 8, 1, 0, 0, 0, 0, 0, 0); tick();
        tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
